sdio_host_cmd_sequencer: RTL

Host-side command-line initiator for the SDIO link, the counterpart of the slave command processor. It runs the card bring-up sequence (CMD5 → CMD3 → CMD7) and then serves single-register CMD52 read/write requests from a user port. It builds 38-bit command words for the command-line transmitter and parses the 38-bit responses from the command-line receiver. It also enforces a response timeout and checks response flags.

---
 rtl/sdio_host_cmd_sequencer_if.sv | 24 ++
 rtl/sdio_host_cmd_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_host_cmd_sequencer_if.sv
// User-side CMD52 request/response channel of the SDIO host command sequencer.
// The master modport belongs to the requester, the slave modport to the sequencer.
interface sdio_host_cmd_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_function;
    logic [16:0] req_address;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [7:0]  rsp_flags;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_function, req_address, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_flags, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_function, req_address, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_flags, rsp_error
    );
endinterface

// File: rtl/sdio_host_cmd_sequencer.sv
// SDIO host command-line initiator: CMD5/CMD3/CMD7 card bring-up, then single
// CMD52 register accesses, with response timeout and R4/R6/R1/R5 flag checks.
module sdio_host_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CMD5_RETRIES   = 100
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start_init,
    sdio_host_cmd_sequencer_if.slave        user,
    output logic                            card_ready,
    output logic                            init_error,
    output logic [15:0]                     card_rca,
    output logic [2:0]                      card_num_functions,
    output logic [37:0]                     cmd_data,
    output logic                            cmd_strobe,
    input  logic                            send_command_in_progress,
    input  logic [37:0]                     resp_data,
    input  logic                            resp_strobe,
    input  logic                            resp_error
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_TX        = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_EVAL      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_CMD5  = 2'd0,
        OP_CMD3  = 2'd1,
        OP_CMD7  = 2'd2,
        OP_CMD52 = 2'd3
    } op_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_LIMIT  = 8'(CMD5_RETRIES);

    function automatic logic [37:0] build_cmd(
        input op_t         op,
        input logic [15:0] rca,
        input logic        wr,
        input logic [2:0]  fn,
        input logic [16:0] addr,
        input logic [7:0]  wdata
    );
        logic [37:0] word;
        case (op)
            OP_CMD5:  word = {6'd5, 8'h00, 24'h3C_0000};
            OP_CMD3:  word = {6'd3, 32'h0000_0000};
            OP_CMD7:  word = {6'd7, rca, 16'h0000};
            OP_CMD52: word = {6'd52, wr, fn, 1'b0, 1'b0, addr, 1'b0, (wr ? wdata : 8'h00)};
            default:  word = 38'h0;
        endcase
        return word;
    endfunction

    // R5 flags that make a CMD52 access fail: COM_CRC, ILLEGAL_CMD, ERROR, FUNC_NUM, OUT_OF_RANGE
    function automatic logic r5_flag_err(input logic [7:0] flags);
        return flags[7] | flags[6] | flags[3] | flags[1] | flags[0];
    endfunction

    state_t      state_r, state_nxt_s;
    op_t         op_r, op_nxt_s;
    logic [37:0] cmd_data_r, cmd_word_s;
    logic        cmd_strobe_r;
    logic        tx_first_r;
    logic [15:0] timer_r;
    logic [7:0]  retry_r;
    logic [37:0] resp_r;
    logic        resp_err_r;
    logic        timeout_r;
    logic        card_ready_r;
    logic        init_error_r;
    logic [15:0] card_rca_r;
    logic [2:0]  card_fn_r;
    logic        rsp_valid_r;
    logic [7:0]  rsp_data_r;
    logic [7:0]  rsp_flags_r;
    logic        rsp_error_r;

    logic req_ready_s;
    logic issue_s, latch_resp_s, timeout_hit_s;
    logic clr_init_s, init_fail_s, init_done_s;
    logic retry_inc_s, latch_fn_s, latch_rca_s;
    logic rsp_fire_s, rsp_err_s;
    logic unused_resp_s;

    assign req_ready_s   = (state_r == ST_IDLE) && card_ready_r && !start_init;
    assign unused_resp_s = ^resp_r;

    // Next-state, op sequencing and bring-up decisions
    always_comb begin
        state_nxt_s   = state_r;
        op_nxt_s      = op_r;
        issue_s       = 1'b0;
        latch_resp_s  = 1'b0;
        timeout_hit_s = 1'b0;
        clr_init_s    = 1'b0;
        init_fail_s   = 1'b0;
        init_done_s   = 1'b0;
        retry_inc_s   = 1'b0;
        latch_fn_s    = 1'b0;
        latch_rca_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_init) begin
                    clr_init_s  = 1'b1;
                    op_nxt_s    = OP_CMD5;
                    issue_s     = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else if (user.req_valid && req_ready_s) begin
                    op_nxt_s    = OP_CMD52;
                    issue_s     = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_TX;
            ST_TX: begin
                // first TX cycle gives the transmitter time to raise its busy flag
                if (!tx_first_r && !send_command_in_progress) begin
                    state_nxt_s = ST_WAIT_RESP;
                end else begin
                    state_nxt_s = ST_TX;
                end
            end
            ST_WAIT_RESP: begin
                if (resp_strobe) begin
                    latch_resp_s = 1'b1;
                    state_nxt_s  = ST_EVAL;
                end else if (timer_r == TIMEOUT_LAST) begin
                    timeout_hit_s = 1'b1;
                    state_nxt_s   = ST_EVAL;
                end else begin
                    state_nxt_s = ST_WAIT_RESP;
                end
            end
            ST_EVAL: begin
                state_nxt_s = ST_IDLE;
                case (op_r)
                    OP_CMD5: begin
                        if (timeout_r || resp_err_r || (resp_r[37:32] != 6'h3F)) begin
                            init_fail_s = 1'b1;
                        end else if (resp_r[31]) begin
                            latch_fn_s  = 1'b1;
                            op_nxt_s    = OP_CMD3;
                            issue_s     = 1'b1;
                            state_nxt_s = ST_ISSUE;
                        end else if ((retry_r + 8'd1) == RETRY_LIMIT) begin
                            init_fail_s = 1'b1;
                        end else begin
                            retry_inc_s = 1'b1;
                            op_nxt_s    = OP_CMD5;
                            issue_s     = 1'b1;
                            state_nxt_s = ST_ISSUE;
                        end
                    end
                    OP_CMD3: begin
                        if (timeout_r || resp_err_r || (resp_r[37:32] != 6'd3) || (resp_r[15:13] != 3'b000)) begin
                            init_fail_s = 1'b1;
                        end else begin
                            latch_rca_s = 1'b1;
                            op_nxt_s    = OP_CMD7;
                            issue_s     = 1'b1;
                            state_nxt_s = ST_ISSUE;
                        end
                    end
                    OP_CMD7: begin
                        if (timeout_r || resp_err_r || (resp_r[37:32] != 6'd7) ||
                            resp_r[23] || resp_r[22] || resp_r[19]) begin
                            init_fail_s = 1'b1;
                        end else begin
                            init_done_s = 1'b1;
                        end
                    end
                    OP_CMD52: state_nxt_s = ST_IDLE;
                    default:  state_nxt_s = ST_IDLE;
                endcase
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        // CMD7 issued straight out of CMD3 evaluation takes the RCA before it is registered
        cmd_word_s = build_cmd(op_nxt_s, (latch_rca_s ? resp_r[31:16] : card_rca_r),
                               user.req_write, user.req_function, user.req_address, user.req_wdata);
    end

    // CMD52 result decode, taken from the live response so rsp_valid follows resp_strobe by one cycle
    always_comb begin
        rsp_fire_s = (op_r == OP_CMD52) && (latch_resp_s || timeout_hit_s);
        if (latch_resp_s) begin
            rsp_err_s = resp_error || (resp_data[37:32] != 6'd52) || r5_flag_err(resp_data[15:8]);
        end else begin
            rsp_err_s = 1'b1;
        end
    end

    // State and op registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            op_r    <= OP_CMD5;
        end else begin
            state_r <= state_nxt_s;
            op_r    <= op_nxt_s;
        end
    end

    // Command word register and one-cycle transmit strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_data_r   <= 38'h0;
            cmd_strobe_r <= 1'b0;
            tx_first_r   <= 1'b0;
        end else begin
            cmd_strobe_r <= issue_s;
            tx_first_r   <= (state_r == ST_ISSUE);
            if (issue_s) begin
                cmd_data_r <= cmd_word_s;
            end
        end
    end

    // Saturating response timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_r <= 16'h0000;
        end else if ((state_r == ST_TX) && (state_nxt_s == ST_WAIT_RESP)) begin
            timer_r <= 16'h0000;
        end else if ((state_r == ST_WAIT_RESP) && (timer_r != 16'hFFFF)) begin
            timer_r <= timer_r + 16'd1;
        end
    end

    // Response capture for bring-up evaluation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_r     <= 38'h0;
            resp_err_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else if (latch_resp_s) begin
            resp_r     <= resp_data;
            resp_err_r <= resp_error;
            timeout_r  <= 1'b0;
        end else if (timeout_hit_s) begin
            resp_r     <= 38'h0;
            resp_err_r <= 1'b0;
            timeout_r  <= 1'b1;
        end
    end

    // Bring-up status, retry counter and card identity
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            card_ready_r <= 1'b0;
            init_error_r <= 1'b0;
            retry_r      <= 8'h00;
            card_rca_r   <= 16'h0000;
            card_fn_r    <= 3'd0;
        end else if (clr_init_s) begin
            card_ready_r <= 1'b0;
            init_error_r <= 1'b0;
            retry_r      <= 8'h00;
        end else begin
            if (init_fail_s) init_error_r <= 1'b1;
            if (init_done_s) card_ready_r <= 1'b1;
            if (retry_inc_s) retry_r      <= retry_r + 8'd1;
            if (latch_fn_s)  card_fn_r    <= resp_r[30:28];
            if (latch_rca_s) card_rca_r   <= resp_r[31:16];
        end
    end

    // CMD52 result port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_flags_r <= 8'h00;
            rsp_error_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_fire_s;
            if (rsp_fire_s) begin
                rsp_data_r  <= latch_resp_s ? resp_data[7:0]  : 8'h00;
                rsp_flags_r <= latch_resp_s ? resp_data[15:8] : 8'h00;
                rsp_error_r <= rsp_err_s;
            end
        end
    end

    assign user.req_ready      = req_ready_s;
    assign user.rsp_valid      = rsp_valid_r;
    assign user.rsp_data       = rsp_data_r;
    assign user.rsp_flags      = rsp_flags_r;
    assign user.rsp_error      = rsp_error_r;
    assign card_ready          = card_ready_r;
    assign init_error          = init_error_r;
    assign card_rca            = card_rca_r;
    assign card_num_functions  = card_fn_r;
    assign cmd_data            = cmd_data_r;
    assign cmd_strobe          = cmd_strobe_r;

endmodule
